// File: rtl/maj_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maj_vote_pkg
// Description : Shared types, limits and helper function for the N-input
//               majority voter (maj_vote_pipe and maj_vote_bit).
//               - vote_mode_e  : VOTE_MAJ (plain majority) / VOTE_STRICT
//                                (unanimity expected, disagreement flagged)
//               - MAX_NUM_IN   : largest supported number of voter inputs
//               - popcount_maj : majority of the low n bits of a vector
// Revision    : 1.0 - initial release
// ============================================================================
package maj_vote_pkg;

    typedef enum logic {
        VOTE_MAJ    = 1'b0,
        VOTE_STRICT = 1'b1
    } vote_mode_e;

    localparam int MAX_NUM_IN = 15;

    // Returns 1 when at least (n+1)/2 of v[n-1:0] are set. Bits at and above
    // n are ignored so callers can zero-extend narrower vectors freely.
    function automatic logic popcount_maj(input logic [MAX_NUM_IN-1:0] v,
                                          input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_NUM_IN; i++) begin
            if (i < n) begin
                ones += int'(v[i]);
            end
        end
        return (ones >= (n + 1) / 2);
    endfunction

endpackage : maj_vote_pkg
`default_nettype wire

// File: rtl/maj_vote_bit.sv
`default_nettype none
// ============================================================================
// Module      : maj_vote_bit
// Description : Combinational single-bit majority of NUM_IN votes.
// Ports       : i_bits [NUM_IN-1:0]  one vote per redundant input
//               o_maj                1 when a majority of i_bits is set
// Revision    : 1.0 - initial release
// ============================================================================
module maj_vote_bit
    import maj_vote_pkg::*;
#(
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN-1:0] i_bits,
    output logic              o_maj
);

    logic [MAX_NUM_IN-1:0] w_ext;

    always_comb begin
        w_ext               = '0;
        w_ext[NUM_IN-1:0]   = i_bits;
        o_maj               = popcount_maj(w_ext, NUM_IN);
    end

endmodule : maj_vote_bit
`default_nettype wire

// File: rtl/maj_vote_pipe.sv
`default_nettype none
// ============================================================================
// Module      : maj_vote_pipe
// Description : Registered NUM_IN-input bitwise majority voter with a
//               valid/ready handshake, per-input disagreement flags and
//               optional per-input saturating disagreement counters with
//               sticky fault flags.
// Ports       : clk, rst_n     clock, asynchronous active-low reset
//               in_valid/in_ready/in_data   input handshake, input i at
//                                           in_data[i*WIDTH +: WIDTH]
//               mode           0 = majority, 1 = strict (flag disagreement)
//               out_valid/out_ready/out_data  voted word handshake
//               out_err        strict mode: some input disagreed
//               disagree_o     inputs that differed from out_data
//               fault_o        sticky per-input fault flags
//               clear_stats    synchronous clear of counters and faults
// Config      : MAJ_VOTE_STATS_EN - when defined, counters, fault_o and
//               clear_stats are functional; otherwise fault_o is tied low
//               and clear_stats is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module maj_vote_pipe
    import maj_vote_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int NUM_IN       = 3,
    parameter int CNT_W        = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic [NUM_IN-1:0]       disagree_o,
    output logic [NUM_IN-1:0]       fault_o,
    input  logic                    clear_stats
);

    if ((NUM_IN % 2) == 0 || NUM_IN < 3 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
        $error("maj_vote_pipe: NUM_IN must be odd and within 3..15");
    end

    logic [WIDTH-1:0]  w_vote;
    logic [NUM_IN-1:0] w_disagree;
    logic              w_err;
    logic              w_accept;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_err;
    logic [NUM_IN-1:0] r_disagree;

    // Per-bit vote: gather bit b of every input into one column and vote it.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_IN-1:0] w_col;

        always_comb begin
            w_col = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                w_col[i] = in_data[i*WIDTH + b];
            end
        end

        maj_vote_bit #(
            .NUM_IN (NUM_IN)
        ) u_bit (
            .i_bits (w_col),
            .o_maj  (w_vote[b])
        );
    end

    always_comb begin
        w_disagree = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_disagree[i] = |(in_data[i*WIDTH +: WIDTH] ^ w_vote);
        end
    end

    assign w_err    = (vote_mode_e'(mode) == VOTE_STRICT) ? |w_disagree : 1'b0;
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Single output stage; everything it holds is only reloaded on accept,
    // so a stalled word (and its mode-dependent out_err) stays frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_disagree  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_vote;
                r_out_err   <= w_err;
                r_disagree  <= w_disagree;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign disagree_o = r_disagree;

`ifdef MAJ_VOTE_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W:0]   c_thresh  = (CNT_W+1)'(FAULT_THRESH);

    logic [CNT_W-1:0]  r_cnt [NUM_IN];
    logic [NUM_IN-1:0] r_fault;

    // Faults compare the registered count, so a flag rises one cycle after
    // its counter crosses the threshold. Clear takes priority over both the
    // count update and the fault set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_cnt[i] <= '0;
            end
            r_fault <= '0;
        end else if (clear_stats) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_cnt[i] <= '0;
            end
            r_fault <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_accept && w_disagree[i] && (r_cnt[i] != c_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                if ({1'b0, r_cnt[i]} >= c_thresh) begin
                    r_fault[i] <= 1'b1;
                end
            end
        end
    end

    assign fault_o = r_fault;
`else
    localparam int c_unused_stats = CNT_W + FAULT_THRESH;
    logic w_unused_clear;

    assign w_unused_clear = clear_stats;
    assign fault_o        = '0;
`endif

endmodule : maj_vote_pipe
`default_nettype wire

// File: tb/tb_maj_vote_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_maj_vote_pipe
// Description : Directed self-checking bench for maj_vote_pipe with
//               WIDTH=4, NUM_IN=3, CNT_W=8, FAULT_THRESH=4. Input words are
//               listed input 0 first: word(a0,a1,a2) puts a0 on input 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maj_vote_pipe;

    localparam int WIDTH        = 4;
    localparam int NUM_IN       = 3;
    localparam int CNT_W        = 8;
    localparam int FAULT_THRESH = 4;

`ifdef MAJ_VOTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic [NUM_IN-1:0]       disagree_o;
    logic [NUM_IN-1:0]       fault_o;
    logic                    clear_stats;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_xfer = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_xfer++;
    end

    maj_vote_pipe #(
        .WIDTH        (WIDTH),
        .NUM_IN       (NUM_IN),
        .CNT_W        (CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .disagree_o  (disagree_o),
        .fault_o     (fault_o),
        .clear_stats (clear_stats)
    );

    task automatic word(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        in_data = {a2, a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", out_err); end
        n_cmp++; if (disagree_o !== 3'b000) begin n_bad++; $display("FAIL reset_disagree: got %b want 000", disagree_o); end
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL reset_fault: got %b want 000", fault_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [11:0] vec_in  [3];
        logic [3:0]  vec_out [3];
        logic [2:0]  vec_dis [3];
        // {a2,a1,a0}: (A,A,5)->A/100, (F,0,F)->F/010, (C,E,6)->E/101
        vec_in[0] = {4'h5, 4'hA, 4'hA}; vec_out[0] = 4'hA; vec_dis[0] = 3'b100;
        vec_in[1] = {4'hF, 4'h0, 4'hF}; vec_out[1] = 4'hF; vec_dis[1] = 3'b010;
        vec_in[2] = {4'h6, 4'hE, 4'hC}; vec_out[2] = 4'hE; vec_dis[2] = 3'b101;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = vec_in[k];
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== vec_out[k]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", k, out_data, vec_out[k]); end
            n_cmp++; if (disagree_o !== vec_dis[k]) begin n_bad++; $display("FAIL basic_disagree[%0d]: got %b want %b", k, disagree_o, vec_dis[k]); end
            n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err[%0d]: got %b want 0", k, out_err); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_strict();
        mode     = 1'b1;
        in_valid = 1'b1;
        word(4'h3, 4'h3, 4'h3);
        tick();
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL strict_agree_err: got %b want 0", out_err); end
        n_cmp++; if (out_data !== 4'h3) begin n_bad++; $display("FAIL strict_agree_data: got %h want 3", out_data); end
        word(4'h3, 4'h7, 4'h3);
        tick();
        n_cmp++; if (out_data !== 4'h3) begin n_bad++; $display("FAIL strict_data: got %h want 3", out_data); end
        n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL strict_err: got %b want 1", out_err); end
        n_cmp++; if (disagree_o !== 3'b010) begin n_bad++; $display("FAIL strict_disagree: got %b want 010", disagree_o); end
        in_valid = 1'b0;
        mode     = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        n_xfer    = 0;
        out_ready = 1'b0;
        mode      = 1'b1;
        in_valid  = 1'b1;
        word(4'h9, 4'h9, 4'h1);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        // Second word waits; mode flips while stalled and must not touch out_err.
        word(4'h6, 4'h6, 4'h6);
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (out_data !== 4'h9 || out_err !== 1'b1 || disagree_o !== 3'b100 || out_valid !== 1'b1)
                begin n_bad++; $display("FAIL bp_hold[%0d]: got %h/%b/%b/%b want 9/1/100/1", k, out_data, out_err, disagree_o, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_data !== 4'h6 || out_err !== 1'b0 || out_valid !== 1'b1)
            begin n_bad++; $display("FAIL bp_next: got %h/%b/%b want 6/0/1", out_data, out_err, out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        n_cmp++; if (n_xfer !== 2) begin n_bad++; $display("FAIL bp_xfer_count: got %0d want 2", n_xfer); end
    endtask

    task automatic test_fault();
        logic [2:0] exp_f;
        exp_f       = STATS ? 3'b001 : 3'b000;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        in_valid    = 1'b1;
        word(4'h5, 4'hA, 4'hA);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (disagree_o !== 3'b001) begin n_bad++; $display("FAIL fault_disagree[%0d]: got %b want 001", k, disagree_o); end
        end
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL fault_early: got %b want 000", fault_o); end
        word(4'hA, 4'hA, 4'hA);
        tick();
        n_cmp++; if (fault_o !== exp_f) begin n_bad++; $display("FAIL fault_set: got %b want %b", fault_o, exp_f); end
        repeat (2) tick();
        n_cmp++; if (fault_o !== exp_f) begin n_bad++; $display("FAIL fault_sticky: got %b want %b", fault_o, exp_f); end
        in_valid    = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL fault_clear: got %b want 000", fault_o); end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_f;
        exp_f    = STATS ? 3'b100 : 3'b000;
        in_valid = 1'b1;
        word(4'hA, 4'hA, 4'h5);
        repeat (300) tick();
        n_cmp++; if (fault_o !== exp_f) begin n_bad++; $display("FAIL sat_fault: got %b want %b", fault_o, exp_f); end
`ifdef MAJ_VOTE_STATS_EN
        n_cmp++; if (dut.r_cnt[2] !== 8'd255) begin n_bad++; $display("FAIL sat_cnt2: got %0d want 255", dut.r_cnt[2]); end
        n_cmp++; if (dut.r_cnt[0] !== 8'd0) begin n_bad++; $display("FAIL sat_cnt0: got %0d want 0", dut.r_cnt[0]); end
`endif
        // Clear coincident with a disagreeing accept: stats drop it, data path does not.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        in_valid    = 1'b0;
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL race_fault: got %b want 000", fault_o); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'hA || disagree_o !== 3'b100)
            begin n_bad++; $display("FAIL race_data: got %b/%h/%b want 1/a/100", out_valid, out_data, disagree_o); end
`ifdef MAJ_VOTE_STATS_EN
        n_cmp++; if (dut.r_cnt[2] !== 8'd0) begin n_bad++; $display("FAIL race_cnt2: got %0d want 0", dut.r_cnt[2]); end
`endif
        tick();
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL race_fault_after: got %b want 000", fault_o); end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_f;
        exp_f     = STATS ? 3'b100 : 3'b000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        word(4'hA, 4'hA, 4'h5);
        repeat (5) tick();
        n_cmp++; if (fault_o !== exp_f) begin n_bad++; $display("FAIL ar_fault_pre: got %b want %b", fault_o, exp_f); end
        out_ready = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_cmp++; if (fault_o !== 3'b000) begin n_bad++; $display("FAIL ar_fault: got %b want 000", fault_o); end
        n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL ar_data: got %h want 0", out_data); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        mode      = 1'b0;
        word(4'h3, 4'h3, 4'h3);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_release_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h3)
            begin n_bad++; $display("FAIL ar_first_word: got %b/%h want 1/3", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        mode        = 1'b0;
        out_ready   = 1'b1;
        clear_stats = 1'b0;
        test_reset();
        test_basic();
        test_strict();
        test_backpressure();
        test_fault();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_maj_vote_pipe
`default_nettype wire
